// File: rtl/soc_system_int_pulse_gen.sv
// Avalon-MM programmable interrupt pulse generator: periodic or triggered pulses
// with optional latching until software acknowledge, plus a missed-event counter.
module soc_system_int_pulse_gen (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    LATCHED = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        ctrl_en_r;
  logic        ctrl_latch_r;
  logic [15:0] period_r;
  logic [7:0]  width_r;
  logic [7:0]  missed_r;
  logic [15:0] cnt_r;
  logic [7:0]  wcnt_r;

  logic        wr_s;
  logic        ctrl_wr_s;
  logic        period_wr_s;
  logic        width_wr_s;
  logic        status_wr_s;
  logic        trig_s;
  logic        ack_s;
  logic        clr_s;
  logic        tick_s;
  logic        event_s;
  logic        load_s;
  logic        miss_s;
  logic [7:0]  eff_width_s;
  logic [31:0] rdata_s;

  assign wr_s        = chipselect & ~write_n;
  assign ctrl_wr_s   = wr_s & (address == 2'd0);
  assign period_wr_s = wr_s & (address == 2'd1);
  assign width_wr_s  = wr_s & (address == 2'd2);
  assign status_wr_s = wr_s & (address == 2'd3);
  assign trig_s      = ctrl_wr_s & writedata[2];
  assign ack_s       = status_wr_s & writedata[0];
  assign clr_s       = status_wr_s & writedata[1];
  assign tick_s      = ctrl_en_r & (period_r != 16'd0) & (cnt_r == (period_r - 16'd1));
  assign event_s     = tick_s | trig_s;
  assign eff_width_s = (width_r == 8'd0) ? 8'd1 : width_r;

  // Next-state logic; an event is consumed only when it can start a fresh pulse.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    miss_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (event_s) begin
          state_s = ASSERT;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ASSERT: begin
        miss_s = event_s;
        if (wcnt_r <= 8'd1) begin
          state_s = ctrl_latch_r ? LATCHED : IDLE;
        end else begin
          state_s = ASSERT;
        end
      end
      LATCHED: begin
        if (ack_s && event_s) begin
          state_s = ASSERT;
          load_s  = 1'b1;
        end else if (ack_s) begin
          state_s = IDLE;
        end else if (event_s) begin
          state_s = LATCHED;
          miss_s  = 1'b1;
        end else begin
          state_s = LATCHED;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Read mux; registered below for one-cycle read latency.
  always_comb begin
    rdata_s = 32'd0;
    case (address)
      2'd0:    rdata_s = {29'd0, (state_r != IDLE), ctrl_latch_r, ctrl_en_r};
      2'd1:    rdata_s = {16'd0, period_r};
      2'd2:    rdata_s = {24'd0, width_r};
      2'd3:    rdata_s = {16'd0, missed_r, 7'd0, out_port};
      default: rdata_s = 32'd0;
    endcase
  end

  // Control registers and read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en_r    <= 1'b0;
      ctrl_latch_r <= 1'b0;
      period_r     <= 16'd0;
      width_r      <= 8'd1;
      readdata     <= 32'd0;
    end else begin
      readdata <= rdata_s;
      if (ctrl_wr_s) begin
        ctrl_en_r    <= writedata[0];
        ctrl_latch_r <= writedata[1];
      end
      if (period_wr_s) begin
        period_r <= writedata[15:0];
      end
      if (width_wr_s) begin
        width_r <= writedata[7:0];
      end
    end
  end

  // Period counter, held at zero whenever it is not free-running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= 16'd0;
    end else if (period_wr_s || !ctrl_en_r || (period_r == 16'd0) || tick_s) begin
      cnt_r <= 16'd0;
    end else begin
      cnt_r <= cnt_r + 16'd1;
    end
  end

  // Pulse FSM, width countdown and missed-event counter (clear beats increment).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      out_port <= 1'b0;
      wcnt_r   <= 8'd0;
      missed_r <= 8'd0;
    end else begin
      state_r  <= state_s;
      out_port <= (state_s != IDLE);
      if (load_s) begin
        wcnt_r <= eff_width_s;
      end else if ((state_r == ASSERT) && (wcnt_r != 8'd0)) begin
        wcnt_r <= wcnt_r - 8'd1;
      end
      if (clr_s) begin
        missed_r <= 8'd0;
      end else if (miss_s && (missed_r != 8'hFF)) begin
        missed_r <= missed_r + 8'd1;
      end
    end
  end

endmodule

// File: doc/soc_system_int_pulse_gen.md
SOC_SYSTEM_INT_PULSE_GEN -- requirements
Module: soc_system_int_pulse_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 address  input  2  Avalon-MM slave word address.
REQ-005 chipselect  input  1  slave select.
REQ-006 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-007 writedata  input  32  write data.
REQ-008 readdata  output  32  registered read data.
REQ-009 out_port  output  1  generated interrupt-style pulse; drives an edge-capture input PIO.

Function
REQ-010 Register map SHALL be:
- 0 CTRL: bit0 EN (periodic enable), bit1 LATCH (latched mode), bit2 TRIG (write-1 one-shot, self-clearing, reads back as BUSY = FSM not IDLE).
- 1 PERIOD: bits[15:0].
- 2 WIDTH: bits[7:0].
- 3 STATUS: read bit0 = out_port, bits[15:8] = MISSED; write bit0=1 ACK, bit1=1 clear MISSED.
REQ-011 Unused read bits SHALL be 0; writes SHALL occur when chipselect=1 and write_n=0.
REQ-012 readdata SHALL be registered every cycle from address, giving 1-cycle read latency and no wait states.
REQ-013 Period counter: 16-bit, runs only while EN=1 and PERIOD!=0, counts 0..PERIOD-1, wraps to 0. A TICK SHALL occur in the cycle the counter equals PERIOD-1.
REQ-014 Period counter SHALL clear to 0 on any PERIOD write, or when EN=0; first TICK SHALL occur PERIOD cycles after the write enabling EN.
REQ-015 An EVENT SHALL be a TICK, a CTRL write with TRIG=1 (regardless of EN), or both in the same cycle (counted as one event).
REQ-016 FSM states SHALL be IDLE, ASSERT, LATCHED; out_port=1 exactly in ASSERT and LATCHED, and is a registered output.
REQ-017 IDLE + EVENT -> ASSERT next cycle; width counter loaded with WIDTH (WIDTH=0 treated as 1).
REQ-018 ASSERT SHALL last exactly the effective width in cycles, then go to LATCHED if LATCH=1, else IDLE.
REQ-019 LATCHED SHALL hold until a STATUS write with bit0=1, then go to IDLE next cycle.
REQ-020 ACK and EVENT in the same cycle while LATCHED SHALL go directly to ASSERT (fresh width load), with no MISSED increment.
REQ-021 An EVENT in ASSERT, or in LATCHED without ACK, SHALL be dropped and increment MISSED (8-bit), saturating at 255.
REQ-022 ACK in IDLE or ASSERT SHALL have no effect.
REQ-023 MISSED clear and increment in the same cycle: clear SHALL win.
REQ-024 Clearing EN or LATCH mid-pulse SHALL NOT truncate ASSERT.
REQ-025 LATCH read at end of ASSERT SHALL decide the next state.
REQ-026 WIDTH/PERIOD writes during ASSERT SHALL affect only later pulses.

Reset
REQ-027 On reset_n=0, immediately and asynchronously:
- out_port=0, readdata=0
- CTRL=0, PERIOD=0, WIDTH=1, MISSED=0
- counters=0, FSM=IDLE
REQ-028 Reset deassertion SHALL start operation on the next clock edge with no spurious pulse.

Verification
REQ-029 WIDTH=3, write CTRL=0x4 -> out_port high for exactly 3 cycles starting the cycle after the write; CTRL readback bit2=1 during the pulse, then 0.
REQ-030 PERIOD=10, WIDTH=2, CTRL=0x1 -> out_port rising edges every 10 cycles, each 2 cycles high, first edge 11 cycles after the CTRL write.
REQ-031 PERIOD=5, WIDTH=1, CTRL=0x3 -> out_port stays high after the first pulse; MISSED increments every 5 cycles; STATUS write 0x1 -> out_port 0 the following cycle.
REQ-032 Latched with 300 missed ticks -> MISSED reads 255; STATUS write 0x2 -> reads 0; ACK coincident with TICK -> new pulse, MISSED unchanged.
REQ-033 reset_n pulsed low mid-ASSERT -> out_port 0 without a clock edge; all registers read defaults (WIDTH=1) after release.
REQ-034 WIDTH=0 trigger -> 1-cycle pulse; PERIOD=0 with EN=1 -> no pulses.
